// File: rtl/quad_pkg.sv
// Shared types for the quadrature generator: FSM states, phase encodings
// and the phase sequencing helper.
package quad_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  // Encoded as {A,B}
  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_10 = 2'b10,
    PH_11 = 2'b11,
    PH_01 = 2'b01
  } phase_t;

  // Forward walks 00->10->11->01->00; reverse walks the same ring backwards.
  function automatic phase_t phase_step(input phase_t cur, input logic fwd);
    phase_t nxt;
    nxt = PH_00;
    case (cur)
      PH_00:   nxt = fwd ? PH_10 : PH_01;
      PH_10:   nxt = fwd ? PH_11 : PH_00;
      PH_11:   nxt = fwd ? PH_01 : PH_10;
      PH_01:   nxt = fwd ? PH_00 : PH_11;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_tick_div.sv
// Edge-rate divider: after load, tick fires every `period` enabled clocks,
// the first one `period` clocks after the load cycle. Period 0 acts as 1.
module quad_tick_div #(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [PER_W-1:0] period,
  output logic             tick
);

  logic [PER_W-1:0] per_q;
  logic [PER_W-1:0] cnt;
  logic [PER_W-1:0] per_eff;

  assign per_eff = (period == '0) ? PER_W'(1) : period;
  assign tick    = en && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      per_q <= per_eff;
      cnt   <= per_eff - PER_W'(1);
    end else if (en) begin
      if (cnt == '0) cnt <= per_q - PER_W'(1);
      else           cnt <= cnt - PER_W'(1);
    end
  end

endmodule

// File: rtl/quad_gen.sv
// Quadrature step generator: emits a counted burst of A/B phase edges at a
// programmable rate and tracks signed position. Index output on quadZ is
// enabled by defining QUAD_GEN_INDEX_EN; otherwise quadZ is tied low.
module quad_gen
  import quad_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_valid,
  output logic             step_ready,
  input  logic             step_dir,
  input  logic [CNT_W-1:0] step_count,
  input  logic [PER_W-1:0] step_period,
  input  logic             stop,
  output logic             quadA,
  output logic             quadB,
  output logic             quadZ,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] position
);

  state_t           state, state_nx;
  phase_t           phase, phase_nx;
  logic [CNT_W-1:0] pos, pos_nx;
  logic [CNT_W-1:0] rem, rem_nx;
  logic             dir, dir_nx;
  logic             done_nx;
  logic             load;
  logic             tick;

  quad_tick_div #(
    .PER_W (PER_W)
  ) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .en     (state == ST_RUN),
    .period (step_period),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      phase <= PH_00;
      pos   <= '0;
      rem   <= '0;
      dir   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
      pos   <= pos_nx;
      rem   <= rem_nx;
      dir   <= dir_nx;
      done  <= done_nx;
    end
  end

  // RUN lingers one cycle at rem==0 after the final edge so done lands in
  // the cycle after that edge; any tick in that cycle is ignored.
  always_comb begin
    state_nx = state;
    phase_nx = phase;
    pos_nx   = pos;
    rem_nx   = rem;
    dir_nx   = dir;
    done_nx  = 1'b0;
    load     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (step_valid) begin
          dir_nx = step_dir;
          if (step_count == '0) begin
            done_nx = 1'b1;
          end else begin
            state_nx = ST_RUN;
            rem_nx   = step_count;
            load     = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop || rem == '0) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end else if (tick) begin
          phase_nx = phase_step(phase, dir);
          pos_nx   = dir ? pos + CNT_W'(1) : pos - CNT_W'(1);
          rem_nx   = rem - CNT_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

`ifdef QUAD_GEN_INDEX_EN
  logic index_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) index_q <= 1'b0;
    else        index_q <= (pos_nx == '0) && (phase_nx == PH_00);
  end

  assign quadZ = index_q;
`else
  assign quadZ = 1'b0;
`endif

  assign step_ready = (state == ST_IDLE);
  assign busy       = (state == ST_RUN);
  assign quadA      = phase[1];
  assign quadB      = phase[0];
  assign position   = pos;

endmodule
